// File: rtl/board_ctrl_pkg.sv
// Shared types and constants for the board reset controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: reset-sequencer state encoding and reset-cause codes.
package board_ctrl_pkg;

   typedef enum logic [1:0] {
      RstPor     = 2'd0,
      RstRun     = 2'd1,
      RstBtnHeld = 2'd2,
      RstStretch = 2'd3
   } rst_state_e;

   localparam logic [1:0] RstCausePor = 2'b01;
   localparam logic [1:0] RstCauseBtn = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one raw input.
// Latency: a raw level change reaches stable_o after 2 + DebounceCycles cycles.
// Backpressure: none; free-running, shorter pulses are dropped.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   in_i      raw input, asynchronous to clk_i
//   stable_o  accepted (debounced) level, resets to ResetVal
module btn_debounce #(
   parameter int unsigned DebounceCycles = 60000,
   parameter logic        ResetVal       = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic stable_o
);

   localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic            meta_q;
   logic            sync_q;
   logic [CntW-1:0] cnt_q;

   // Synchronizer resets to the idle level so no false edge is seen after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q   <= ResetVal;
         sync_q   <= ResetVal;
         cnt_q    <= '0;
         stable_o <= ResetVal;
      end else begin
         meta_q <= in_i;
         sync_q <= meta_q;
         if (sync_q == stable_o) begin
            cnt_q <= '0;
         end else if (cnt_q == CntLast) begin
            // Mismatch held for DebounceCycles consecutive cycles: accept it.
            stable_o <= sync_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_rst_ctrl.sv
// Board reset sequencer: stretches POR, debounces the reset button, filters user buttons.
// Latency: soc_rst_no rises PorCycles edges after rst_ni release; falls 3 + DebounceCycles after a press.
// Backpressure: none; outputs are level signals.
//
// Ports:
//   clk_i        system clock (6 MHz HFOSC)
//   rst_ni       asynchronous active-low power-on reset
//   btn_rst_ni   raw active-low reset button, asynchronous
//   btn_i        raw active-high user buttons, asynchronous
//   btn_o        conditioned user buttons towards the SoC gpio inputs
//   soc_rst_no   registered active-low SoC reset, released synchronously
//   rst_cause_o  cause of last SoC reset (01 power-on, 10 button)
//
// Build option: BOARD_RST_CTRL_GPIO_DEBOUNCE_EN debounces the user buttons;
// otherwise they are only synchronized. The reset button is always debounced.
module board_rst_ctrl
   import board_ctrl_pkg::*;
#(
   parameter int unsigned PorCycles      = 4096,
   parameter int unsigned DebounceCycles = 60000,
   parameter int unsigned NumBtn         = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              btn_rst_ni,
   input  logic [NumBtn-1:0] btn_i,
   output logic [NumBtn-1:0] btn_o,
   output logic              soc_rst_no,
   output logic [1:0]        rst_cause_o
);

   localparam int unsigned     PorW    = (PorCycles > 1) ? $clog2(PorCycles) : 1;
   localparam logic [PorW-1:0] PorLast = PorW'(PorCycles - 1);

   rst_state_e      state_q, state_d;
   logic [PorW-1:0] por_cnt_q, por_cnt_d;
   logic [1:0]      cause_d;
   logic            btn_rst_stable;

   btn_debounce #(
      .DebounceCycles (DebounceCycles),
      .ResetVal       (1'b1)
   ) u_rst_btn (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .in_i     (btn_rst_ni),
      .stable_o (btn_rst_stable)
   );

   // The counter is shared by POR and STRETCH; it is cleared in every other
   // state, so entering STRETCH always starts a full stretch.
   always_comb begin
      state_d   = state_q;
      por_cnt_d = '0;
      cause_d   = rst_cause_o;
      case (state_q)
         RstPor: begin
            if (por_cnt_q == PorLast) begin
               state_d = btn_rst_stable ? RstRun : RstBtnHeld;
            end else begin
               por_cnt_d = por_cnt_q + 1'b1;
            end
         end
         RstRun: begin
            if (!btn_rst_stable) begin
               state_d = RstBtnHeld;
            end
         end
         RstBtnHeld: begin
            if (btn_rst_stable) begin
               state_d = RstStretch;
            end
         end
         RstStretch: begin
            // A re-press wins over stretch completion.
            if (!btn_rst_stable) begin
               state_d = RstBtnHeld;
            end else if (por_cnt_q == PorLast) begin
               state_d = RstRun;
            end else begin
               por_cnt_d = por_cnt_q + 1'b1;
            end
         end
         default: state_d = RstPor;
      endcase
      if ((state_d == RstBtnHeld) && (state_q != RstBtnHeld)) begin
         cause_d = RstCauseBtn;
      end
   end

   // soc_rst_no follows the next state so it toggles on the same edge as state_q.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RstPor;
         por_cnt_q   <= '0;
         soc_rst_no  <= 1'b0;
         rst_cause_o <= RstCausePor;
      end else begin
         state_q     <= state_d;
         por_cnt_q   <= por_cnt_d;
         soc_rst_no  <= (state_d == RstRun);
         rst_cause_o <= cause_d;
      end
   end

`ifdef BOARD_RST_CTRL_GPIO_DEBOUNCE_EN
   for (genvar i = 0; i < NumBtn; i++) begin : g_btn_db
      btn_debounce #(
         .DebounceCycles (DebounceCycles),
         .ResetVal       (1'b0)
      ) u_btn_db (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .in_i     (btn_i[i]),
         .stable_o (btn_o[i])
      );
   end
`else
   logic [NumBtn-1:0] btn_meta_q;
   logic [NumBtn-1:0] btn_sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_meta_q <= '0;
         btn_sync_q <= '0;
      end else begin
         btn_meta_q <= btn_i;
         btn_sync_q <= btn_meta_q;
      end
   end

   assign btn_o = btn_sync_q;
`endif

endmodule

// File: tb/tb_board_rst_ctrl.sv
// Scoreboard bench for board_rst_ctrl with PorCycles=8, DebounceCycles=4.
// Stimulus pushes expected output-change events (signal, value, cycle);
// a monitor on the falling edge pops and compares every observed change.
module tb_board_rst_ctrl;

   localparam int SigRst   = 0;
   localparam int SigCause = 1;
   localparam int SigBtn   = 2;

   typedef struct {
      int sig;
      int val;
      int cyc;
   } evt_t;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       btn_rst_ni;
   logic [2:0] btn_i;
   logic [2:0] btn_o;
   logic       soc_rst_no;
   logic [1:0] rst_cause_o;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;
   evt_t exp_q[$];

   logic       prev_rst   = 1'b0;
   logic [1:0] prev_cause = 2'b01;
   logic [2:0] prev_btn   = 3'b000;

   board_rst_ctrl #(
      .PorCycles      (8),
      .DebounceCycles (4),
      .NumBtn         (3)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .btn_rst_ni  (btn_rst_ni),
      .btn_i       (btn_i),
      .btn_o       (btn_o),
      .soc_rst_no  (soc_rst_no),
      .rst_cause_o (rst_cause_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push_evt(input int sig, input int val, input int at);
      evt_t e;
      e.sig = sig;
      e.val = val;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic evt_seen(input int sig, input int val);
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_change: sig=%0d val=%0d at cycle %0d, required no change",
                  sig, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.sig != sig || e.val != val || e.cyc != cyc) begin
            errors++;
            $display("FAIL output_change: got sig=%0d val=%0d cycle=%0d, required sig=%0d val=%0d cycle=%0d",
                     sig, val, cyc, e.sig, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: any change on an output is an event that must match the queue head.
   always @(negedge clk_i) begin
      if (mon_en) begin
         if (soc_rst_no !== prev_rst) begin
            evt_seen(SigRst, int'(soc_rst_no));
            prev_rst = soc_rst_no;
         end
         if (rst_cause_o !== prev_cause) begin
            evt_seen(SigCause, int'(rst_cause_o));
            prev_cause = rst_cause_o;
         end
         if (btn_o !== prev_btn) begin
            evt_seen(SigBtn, int'(btn_o));
            prev_btn = btn_o;
         end
      end
   end

   initial begin
      int b;
      int wait_cnt;
      rst_ni     = 1'b0;
      btn_rst_ni = 1'b1;
      btn_i      = 3'b000;
      tick(3);
      chk("reset_soc_rst_no", int'(soc_rst_no), 0);
      chk("reset_rst_cause", int'(rst_cause_o), 1);
      chk("reset_btn_o", int'(btn_o), 0);
      mon_en = 1'b1;

      // Power-on release with button idle: SoC released on edge 8.
      b = cyc;
      push_evt(SigRst, 1, b + 8);
      rst_ni = 1'b1;
      tick(12);

      // 3-cycle reset-button glitch: filtered out, no output change.
      btn_rst_ni = 1'b0;
      tick(3);
      btn_rst_ni = 1'b1;
      tick(12);

      // 20-cycle press: fall after 7, cause 10, rise 15 after release.
      b = cyc;
      push_evt(SigRst, 0, b + 7);
      push_evt(SigCause, 2, b + 7);
      push_evt(SigRst, 1, b + 35);
      btn_rst_ni = 1'b0;
      tick(20);
      btn_rst_ni = 1'b1;
      tick(25);

      // Re-press for 10 cycles during STRETCH: no early release, full stretch after.
      b = cyc;
      push_evt(SigRst, 0, b + 7);
      push_evt(SigRst, 1, b + 49);
      btn_rst_ni = 1'b0;
      tick(20);
      btn_rst_ni = 1'b1;
      tick(4);
      btn_rst_ni = 1'b0;
      tick(10);
      btn_rst_ni = 1'b1;
      tick(25);

      // rst_ni asserted mid-STRETCH: cause 01 at once, then a fresh 8-cycle POR.
      b = cyc;
      push_evt(SigRst, 0, b + 7);
      push_evt(SigCause, 1, b + 30);
      push_evt(SigRst, 1, b + 41);
      btn_rst_ni = 1'b0;
      tick(20);
      btn_rst_ni = 1'b1;
      tick(10);
      rst_ni = 1'b0;
      tick(3);
      rst_ni = 1'b1;
      tick(15);

      // rst_ni asserted in RUN: SoC reset drops before the next clock edge.
      b = cyc;
      push_evt(SigRst, 0, b);
      push_evt(SigRst, 1, b + 10);
      rst_ni = 1'b0;
      tick(2);
      rst_ni = 1'b1;
      tick(14);

      // Button held through power-on: POR ends in BTN_HELD with cause 10.
      b = cyc;
      push_evt(SigRst, 0, b);
      rst_ni     = 1'b0;
      btn_rst_ni = 1'b0;
      tick(2);
      b = cyc;
      push_evt(SigCause, 2, b + 8);
      push_evt(SigRst, 1, b + 27);
      rst_ni = 1'b1;
      tick(12);
      btn_rst_ni = 1'b1;
      tick(20);

      // btn_i[1] bouncing with 2-cycle pulses, steady high from b+8, low at b+28.
      b = cyc;
`ifdef BOARD_RST_CTRL_GPIO_DEBOUNCE_EN
      push_evt(SigBtn, 2, b + 14);
      push_evt(SigBtn, 0, b + 34);
`else
      push_evt(SigBtn, 2, b + 2);
      push_evt(SigBtn, 0, b + 4);
      push_evt(SigBtn, 2, b + 6);
      push_evt(SigBtn, 0, b + 8);
      push_evt(SigBtn, 2, b + 10);
      push_evt(SigBtn, 0, b + 30);
`endif
      for (int i = 0; i < 4; i++) begin
         btn_i = (i % 2 == 0) ? 3'b010 : 3'b000;
         tick(2);
      end
      btn_i = 3'b010;
      tick(20);
      btn_i = 3'b000;
      tick(12);

      // Every expected event must have been observed.
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 50) begin
         tick(1);
         wait_cnt++;
      end
      chk("pending_events", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_rst_ctrl.md
# board_rst_ctrl

Board-level reset sequencer and button conditioner sitting between the iCEBreaker pins and the `zerosoc` instance. It stretches power-on reset and debounces the active-low reset button, then drives a clean, synchronously released reset into the SoC's `rst_ni`. It also filters the three user buttons before they reach `gpio_i`, and reports the cause of the most recent SoC reset.

## Interface
- `PorCycles`, default 4096: cycles `soc_rst_no` stays low after `rst_ni` release and after a button release; minimum 1.
- `DebounceCycles`, default 60000 (10 ms at 6 MHz): consecutive stable cycles required to accept a new input level; minimum 1.
- `NumBtn`, default 3: user button count.

- `clk_i`  in  1  system clock (6 MHz HFOSC).
- `rst_ni`  in  1  reset, asynchronous, active-low (global/power-on).
- `btn_rst_ni`  in  1  raw reset button, active-low, asynchronous to `clk_i`.
- `btn_i`  in  NumBtn  raw user buttons, active-high, asynchronous.
- `btn_o`  out  NumBtn  conditioned buttons to SoC `gpio_i`.
- `soc_rst_no`  out  1  SoC reset, active-low, registered.
- `rst_cause_o`  out  2  cause of last SoC reset: 01 POR, 10 button; 00 and 11 unused.

## Operation
- Every raw input passes a 2-flop synchronizer. Reset values: 1 for `btn_rst_ni`, 0 for `btn_i`.
- Debounce per channel:
  - `stable` holds the accepted level; reset value matches the synchronizer.
  - Counter increments while the synchronized value differs from `stable` and clears when it matches.
  - On reaching `DebounceCycles-1` with a mismatch, `stable` takes the new value and the counter clears.
  - Counter width is `$clog2(DebounceCycles+1)`.
- FSM states:
  - **POR**: counts up to `PorCycles-1`. At the end it goes to BTN_HELD (cause 10) if the reset button's `stable` is 0, otherwise to RUN.
  - **RUN**: goes to BTN_HELD when the reset button's `stable` is 0.
  - **BTN_HELD**: goes to STRETCH when `stable` returns to 1; the counter clears.
  - **STRETCH**: counts up to `PorCycles-1`, then goes to RUN. If `stable` returns to 0 first, it goes back to BTN_HELD.
- `soc_rst_no` is 1 only in RUN. It is registered from the next state, so it changes in the same cycle the state changes.
- `rst_cause_o`:
  - Set to 01 by `rst_ni` assertion.
  - Set to 10 on entry to BTN_HELD.
  - Otherwise holds its value.
- Reset values: state POR, counters 0, `soc_rst_no` 0, `btn_o` 0, `rst_cause_o` 01.

## Timing
- `soc_rst_no` rises exactly `PorCycles` rising edges after `rst_ni` deassertion, provided the button is not pressed.
- A raw input change to `stable` takes 2 + `DebounceCycles` cycles. `soc_rst_no` falls one cycle after that, i.e. 3 + `DebounceCycles` cycles after the button press.
- Button release to `soc_rst_no` rising takes 2 + `DebounceCycles` + `PorCycles` + 1 cycles.
- Any pulse or bounce shorter than `DebounceCycles` synchronized cycles is ignored.
- `rst_ni` assertion at any point, including mid-STRETCH, drives `soc_rst_no` low asynchronously and restarts POR.
- `soc_rst_no` assertion from the button is synchronous; its release is always synchronous to `clk_i`.

## Configuration
- `BOARD_RST_CTRL_GPIO_DEBOUNCE_EN` defined: `btn_o` is each user button's debounced `stable`.
- Undefined: `btn_o` is the 2-flop synchronizer output, with 2-cycle latency and no filtering. User-button debounce counters are not instantiated.
- The reset-button path is always debounced, regardless of the macro.

## Structure
- Package `board_ctrl_pkg` holds:
  - The state enum: `RstPor`, `RstRun`, `RstBtnHeld`, `RstStretch`.
  - The cause constants: `RstCausePor`=2'b01, `RstCauseBtn`=2'b10.
- Sub-module `btn_debounce`:
  - Parameters: `DebounceCycles`, `ResetVal`.
  - Contents: synchronizer plus counter.
  - Instantiated once for the reset button, and `NumBtn` times when the macro is defined.

## Test plan
Bench parameters: `PorCycles`=8, `DebounceCycles`=4.
- Release `rst_ni` with button idle -> `soc_rst_no` 0 for 8 cycles, then 1 at edge 8; `rst_cause_o`=01.
- Reset button in RUN, low 3 cycles -> `soc_rst_no` stays 1; cause unchanged.
- Reset button low 20 cycles -> `soc_rst_no` falls 7 cycles after the press; cause 10. `soc_rst_no` rises 15 cycles after release.
- Reset button re-pressed for 10 cycles mid-STRETCH -> returns to BTN_HELD; the full 8-cycle stretch restarts after release.
- `rst_ni` asserted mid-STRETCH -> `soc_rst_no` is 0 immediately; cause 01; POR 8-cycle sequence on release.
- `btn_i[1]` bouncing with 2-cycle pulses, then steady high:
  - With the macro: `btn_o[1]` rises only 6 cycles after the steady level.
  - Without the macro: `btn_o[1]` follows `btn_i[1]` with a 2-cycle delay.
